uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised receive-side byte buffer between the UART receiver and downstream consumers. It accepts one strobed word per cycle and optionally discards all-zero words. Accepted words are queued in a DEPTH-entry first-word-fall-through FIFO and released over a valid/ready handshake. Sticky overflow reporting and occupancy status replace the single-register, single-cycle `ready` pulse of the previous buffer generation.

## Interface

Parameters:
- DATA_W, 8, word width in bits
- DEPTH, 16, FIFO entries; power of two, 2..256
- DROP_NULL, 1, 1 = discard words equal to all-zero; 0 = queue them like any other word

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  write strobe, one word per cycle while high
- in_data  input  DATA_W  word to write
- out_data  output  DATA_W  head-of-queue word; 0 when out_valid=0
- out_valid  output  1  queue non-empty, out_data is meaningful
- out_ready  input  1  consumer takes the head word when out_valid && out_ready
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a word was lost because the FIFO was full
- ovf_clr  input  1  clears overflow
- null_seen  output  1  one-cycle pulse: a word was discarded by DROP_NULL

## Operation

- reset=1 at a rising edge:
  - count, rd_ptr, wr_ptr, overflow, null_seen → 0; empty → 1; full, out_valid → 0; out_data → 0.
  - Memory contents are don't-care.
- Qualification: null = DROP_NULL && in_data == 0.
  - push_req = in_valid && !null.
  - pop = out_valid && out_ready.
- Push accepted when push_req && (!full || pop).
  - At full, a simultaneous pop frees the slot and the push is accepted.
  - On accept: mem[wr_ptr] ← in_data; wr_ptr increments modulo DEPTH.
- Push rejected when push_req && full && !pop:
  - The word is dropped and overflow ← 1.
  - FIFO contents, pointers and count are unchanged.
- Pop: rd_ptr increments modulo DEPTH; the head word advances.
- count update: count + accepted_push − pop.
  - Simultaneous push and pop leaves count unchanged.
- Null word with in_valid=1: not queued; null_seen=1 for the next cycle only. Count, pointers and overflow are unaffected.
- ovf_clr has priority over a same-cycle overflow set: overflow ends at 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from count, not from pointer comparison.
- out_data = mem[rd_ptr] when out_valid=1, else 0. This is a combinational read of the registered head.
- With DEPTH=1 not permitted: the parameter is checked by an elaboration-time assertion.

## Timing

- Write-to-visible latency is 1 cycle. A word accepted at edge N gives out_valid=1 and out_data valid in the cycle after edge N.
- Same-cycle fall-through is not provided: an empty FIFO never forwards in_data combinationally.
- Pop takes effect at the edge where out_valid && out_ready. The next word, or out_valid=0, appears after that edge.
- Sustained throughput is 1 word/cycle in and 1 word/cycle out simultaneously, at any occupancy including full.
- count, full, empty, overflow and null_seen are registered and update at the same edge as the pointers.
- out_ready while out_valid=0 is ignored and does not underflow.
- Reset asserted mid-stream discards all queued words at that edge. in_valid during reset is ignored.

## Test plan

- **Basic order:** after reset, write 0x11, 0x22, 0x33 on consecutive cycles with out_ready=0.
  - count=3, out_data=0x11.
  - Raise out_ready for 3 cycles → reads 0x11, 0x22, 0x33; then empty=1, out_data=0.
- **Null filter:** DROP_NULL=1, write 0x00 then 0x5A.
  - null_seen pulses once; count=1; out_data=0x5A.
  - With DROP_NULL=0, the same stimulus gives count=2 and head 0x00.
- **Overflow:** DEPTH=16, out_ready=0, write 0x01..0x11 (17 words).
  - full=1 after the 16th write; overflow=1 after the 17th.
  - Drain returns 0x01..0x10, with 0x11 lost.
  - Pulse ovf_clr → overflow=0.
- **Full with simultaneous push/pop:** at count=16, in_valid=1 with 0xAB and out_ready=1.
  - count stays 16; overflow stays 0.
  - 0xAB emerges after 15 further pops.
- **Wrap-around:** stream 40 incrementing words with out_ready randomly toggled.
  - Output sequence matches input exactly; count never exceeds 16.
- **Reset mid-operation:** with count=5, assert reset one cycle.
  - Next cycle count=0, empty=1, out_valid=0, overflow=0.
  - A subsequent write of 0x77 appears as head after 1 cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side word buffer: optional null-word filter in front of a first-word-fall-through
// FIFO, with sticky overflow reporting and registered occupancy status.
module uart_rx_fifo #(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int unsigned DROP_NULL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic                       null_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  logic          is_null;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          push_rej;
  logic [CW-1:0] count_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    is_null   = (DROP_NULL != 0) && (in_data == '0);
    push_req  = in_valid && !is_null;
    pop       = out_valid && out_ready;
    push_ok   = push_req && (!full || pop);
    push_rej  = push_req && full && !pop;
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      null_seen <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      null_seen <= in_valid && is_null;
      // Clear wins over a same-cycle loss so software never misses its acknowledge.
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (push_rej) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] out_data, out_data0;
  logic       out_valid, out_valid0;
  logic [4:0] count, count0;
  logic       full, full0, empty, empty0;
  logic       overflow, overflow0, null_seen, null_seen0;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the DROP_NULL=1 instance
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_null;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_NULL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .ovf_clr(ovf_clr), .null_seen(null_seen)
  );

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_NULL(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .count(count0), .full(full0), .empty(empty0), .overflow(overflow0),
    .ovf_clr(ovf_clr), .null_seen(null_seen0)
  );

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    out_ready = 1'b0;
    ovf_clr  = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    q.delete();
    m_ovf  = 1'b0;
    m_null = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, report what the DUT presented if a pop happened.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic clr,
                       output logic popped, output logic [7:0] dut_word,
                       output logic [7:0] exp_word, output logic accepted);
    logic preq, rej;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    ovf_clr   = clr;
    #1;
    dut_word = out_data;
    popped   = (q.size() > 0) && r;
    exp_word = popped ? q[0] : 8'h00;
    preq     = v && (d != 8'h00);
    accepted = preq && ((q.size() < DEPTH) || popped);
    rej      = preq && (q.size() == DEPTH) && !popped;
    if (popped) void'(q.pop_front());
    if (accepted) q.push_back(d);
    if (clr) m_ovf = 1'b0;
    else if (rej) m_ovf = 1'b1;
    m_null = v && (d == 8'h00);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || overflow !== 1'b0 || null_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b data=%h ovf=%b null=%b, want 0 1 0 0 00 0 0",
               count, empty, full, out_valid, out_data, overflow, null_seen);
    end
  endtask

  task automatic test_basic_order();
    logic p, a;
    logic [7:0] dw, ew;
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, words[i], 1'b0, 1'b0, p, dw, ew, a);
    checks++;
    if (count !== 5'd3 || out_data !== 8'h11 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: count=%0d data=%h valid=%b, want 3 11 1", count, out_data, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, p, dw, ew, a);
      checks++;
      if (!p || dw !== words[i] || ew !== words[i]) begin
        errors++;
        $display("FAIL basic_read%0d: got %h, want %h", i, dw, words[i]);
      end
    end
    checks++;
    if (empty !== 1'b1 || out_data !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: empty=%b data=%h valid=%b, want 1 00 0", empty, out_data, out_valid);
    end
  endtask

  task automatic test_null_filter();
    logic p, a;
    logic [7:0] dw, ew;
    do_reset();
    cycle(1'b1, 8'h00, 1'b0, 1'b0, p, dw, ew, a);
    checks++;
    if (null_seen !== m_null || count !== 5'(q.size()) || null_seen0 !== 1'b0) begin
      errors++;
      $display("FAIL null_pulse: null_seen=%b count=%0d null_seen(drop0)=%b, want %b %0d 0",
               null_seen, count, null_seen0, m_null, q.size());
    end
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, p, dw, ew, a);
    checks++;
    if (null_seen !== 1'b0 || count !== 5'd1 || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL null_drop: null_seen=%b count=%0d data=%h, want 0 1 5a", null_seen, count, out_data);
    end
    checks++;
    if (count0 !== 5'd2 || out_data0 !== 8'h00 || out_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL null_keep: count=%0d data=%h valid=%b, want 2 00 1", count0, out_data0, out_valid0);
    end
  endtask

  task automatic test_overflow();
    logic p, a;
    logic [7:0] dw, ew;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, p, dw, ew, a);
      if (i == 16) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0 || count !== 5'd16) begin
          errors++;
          $display("FAIL ovf_full: full=%b ovf=%b count=%0d, want 1 0 16", full, overflow, count);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b count=%0d, want 1 16", overflow, count);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, p, dw, ew, a);
      checks++;
      if (dw !== 8'(i) || ew !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h, want %h", i, dw, 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_lost: empty=%b ovf=%b, want 1 1", empty, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, p, dw, ew, a);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b, want 0", overflow);
    end
    // Fill again and collide a rejected push with a clear: the clear must win.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, p, dw, ew, a);
    cycle(1'b1, 8'h99, 1'b0, 1'b1, p, dw, ew, a);
    checks++;
    if (overflow !== m_ovf || overflow !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL ovf_clr_priority: ovf=%b count=%0d, want 0 16", overflow, count);
    end
  endtask

  task automatic test_full_push_pop();
    logic p, a;
    logic [7:0] dw, ew;
    // Continues from a full FIFO left by test_overflow.
    cycle(1'b1, 8'hAB, 1'b1, 1'b0, p, dw, ew, a);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || !a || dw !== ew) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d ovf=%b full=%b popped=%h, want 16 0 1 %h", count, overflow, full, dw, ew);
    end
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, p, dw, ew, a);
      checks++;
      if (dw !== ew) begin
        errors++;
        $display("FAIL full_drain%0d: got %h, want %h", i, dw, ew);
      end
    end
    checks++;
    if (out_data !== 8'hAB || count !== 5'd1 || q[0] !== 8'hAB) begin
      errors++;
      $display("FAIL full_tail: head=%h count=%0d, want ab 1", out_data, count);
    end
  endtask

  task automatic test_wrap_around();
    logic p, a;
    logic [7:0] dw, ew;
    int sent = 0, got = 0;
    do_reset();
    for (int c = 0; c < 600 && got < 40; c++) begin
      logic v;
      v = (sent < 40) && ($urandom_range(0, 3) != 0);
      cycle(v, 8'(sent + 1), 1'($urandom_range(0, 1)), 1'b0, p, dw, ew, a);
      if (a) sent++;
      if (p) begin
        got++;
        checks++;
        if (dw !== ew || dw !== 8'(got)) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h, want %h", got, dw, 8'(got));
        end
      end
      checks++;
      if (count !== 5'(q.size()) || count > 5'd16) begin
        errors++;
        $display("FAIL wrap_count: count=%0d, want %0d", count, q.size());
      end
    end
    checks++;
    if (got != 40) begin
      errors++;
      $display("FAIL wrap_timeout: received %0d words, want 40", got);
    end
  endtask

  task automatic test_reset_mid();
    logic p, a;
    logic [7:0] dw, ew;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, p, dw, ew, a);
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL mid_prefill: count=%0d, want 5", count);
    end
    do_reset();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b valid=%b ovf=%b, want 0 1 0 0", count, empty, out_valid, overflow);
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b0, p, dw, ew, a);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77 || count !== 5'd1) begin
      errors++;
      $display("FAIL mid_write: valid=%b data=%h count=%0d, want 1 77 1", out_valid, out_data, count);
    end
  endtask

  task automatic test_back_to_back();
    logic p, a;
    logic [7:0] dw, ew;
    logic [7:0] d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      // Bias toward writes early so the full/overflow corner is visited.
      cycle(1'($urandom_range(0, 3) != 0), d, 1'(c > 60 ? $urandom_range(0, 1) : ($urandom_range(0, 5) == 0)),
            1'($urandom_range(0, 15) == 0), p, dw, ew, a);
      checks++;
      if ((p && dw !== ew) || count !== 5'(q.size()) || overflow !== m_ovf || null_seen !== m_null ||
          out_valid !== (q.size() > 0) || out_data !== ((q.size() > 0) ? q[0] : 8'h00) ||
          full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++;
        $display("FAIL random_cycle%0d: popped=%h/%h count=%0d/%0d ovf=%b/%b null=%b/%b head=%h",
                 c, dw, ew, count, q.size(), overflow, m_ovf, null_seen, m_null, out_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_order();
    test_null_filter();
    test_overflow();
    test_full_push_pop();
    test_wrap_around();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
